// File: rtl/sub_arb_pkg.sv
// Shared types for the round-robin subtractor arbiter: operand width,
// response-slot state and the registered result record.
package sub_arb_pkg;

  localparam int WIDTH    = 8;
  localparam int ID_MAX_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    FULL = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic [WIDTH-1:0]    diff;
    logic                borrow;
    logic                ovf;
    logic [ID_MAX_W-1:0] id;
  } sub_result_t;

endpackage

// File: rtl/subtract_8bit.sv
// Shared 8-bit subtractor datapath: two's-complement a + ~b + 1.
module subtract_8bit (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result
);

  assign result = a + ~b + 8'd1;

endmodule

// File: rtl/sub_share_arb.sv
// Round-robin scheduler sharing one subtract_8bit between NREQ requesters,
// with a single registered valid/ready response slot.
module sub_share_arb #(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = sub_arb_pkg::WIDTH,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_diff,
  output logic                  rsp_borrow,
  output logic                  rsp_ovf,
  output logic [IDW-1:0]        rsp_id,
  output logic [15:0]           op_count
);
  import sub_arb_pkg::*;

  arb_state_t  state_q;
  sub_result_t res_q, res_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [15:0]    cnt_q;

  logic             slot_free, any_vld, xfer;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] a_sel, b_sel, diff;
  logic             cin_msb, cout;
  logic             id_unused;

  // First set bit scanning ptr, ptr+1, ... modulo NREQ; MSB of result = found.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic           found;
    logic [IDW-1:0] idx;
    int             cand;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = (int'(ptr) + k) % NREQ;
      if (!found && vld[cand]) begin
        found = 1'b1;
        idx   = IDW'(cand);
      end
    end
    return {found, idx};
  endfunction

  subtract_8bit u_sub (
    .a      (a_sel),
    .b      (b_sel),
    .result (diff)
  );

  always_comb begin
    {any_vld, gnt_idx} = rr_pick(req_valid, ptr_q);
    slot_free = (state_q == IDLE) || rsp_ready;
    xfer      = rst_n && slot_free && any_vld;
    req_ready = '0;
    if (xfer) req_ready[gnt_idx] = 1'b1;
    a_sel = req_a[int'(gnt_idx)*WIDTH +: WIDTH];
    b_sel = req_b[int'(gnt_idx)*WIDTH +: WIDTH];
    // Carry into the MSB is recovered from the sum bit, then carried out.
    cin_msb = diff[WIDTH-1] ^ a_sel[WIDTH-1] ^ ~b_sel[WIDTH-1];
    cout    = (a_sel[WIDTH-1] & ~b_sel[WIDTH-1]) |
              ((a_sel[WIDTH-1] ^ ~b_sel[WIDTH-1]) & cin_msb);
    res_d.diff   = diff;
    res_d.borrow = ~cout;
    res_d.ovf    = (a_sel[WIDTH-1] != b_sel[WIDTH-1]) &&
                   (diff[WIDTH-1] != a_sel[WIDTH-1]);
    res_d.id     = ID_MAX_W'(gnt_idx);
    ptr_d        = (int'(gnt_idx) == NREQ-1) ? '0 : gnt_idx + IDW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      res_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else if (xfer) begin
      state_q <= FULL;
      res_q   <= res_d;
      ptr_q   <= ptr_d;
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end else if (state_q == FULL && rsp_ready) begin
      state_q <= IDLE;
    end
  end

  // The id field is sized for 8 requesters; upper bits idle for smaller NREQ.
  assign id_unused  = ^res_q.id;
  assign rsp_valid  = (state_q == FULL);
  assign rsp_diff   = res_q.diff;
  assign rsp_borrow = res_q.borrow;
  assign rsp_ovf    = res_q.ovf;
  assign rsp_id     = res_q.id[IDW-1:0];
  assign op_count   = cnt_q;

endmodule

// File: tb/tb_sub_share_arb.sv
// Scoreboard bench for sub_share_arb: per-requester operand queues feed the DUT,
// expected responses are queued and checked by an independent monitor.
module tb_sub_share_arb;

  localparam int NREQ = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ready;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_diff;
  logic        rsp_borrow;
  logic        rsp_ovf;
  logic [1:0]  rsp_id;
  logic [15:0] op_count;

  logic [15:0] opq [NREQ][$];
  logic [11:0] sb [$];
  logic [3:0]  xm = '0;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          start_cyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sub_share_arb #(.NREQ(NREQ), .WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_diff   (rsp_diff),
    .rsp_borrow (rsp_borrow),
    .rsp_ovf    (rsp_ovf),
    .rsp_id     (rsp_id),
    .op_count   (op_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic put(input int i, input logic [7:0] a, input logic [7:0] b);
    opq[i].push_back({a, b});
  endtask

  task automatic exp_raw(input logic [7:0] d, input logic bo, input logic ov, input logic [1:0] id);
    sb.push_back({d, bo, ov, id});
  endtask

  function automatic logic [11:0] model(input logic [7:0] a, input logic [7:0] b, input logic [1:0] id);
    int         sd;
    logic [7:0] d;
    sd = int'($signed(a)) - int'($signed(b));
    d  = a - b;
    return {d, (a < b), (sd > 127 || sd < -128), id};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    bit done;
    bit empty;
    n = 0;
    done = 1'b0;
    while (!done) begin
      @(negedge clk);
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (opq[i].size() != 0) empty = 1'b0;
      if (empty && sb.size() == 0 && !rsp_valid) done = 1'b1;
      else if (++n > 300) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got %0d pending responses, expected 0", name, sb.size());
        done = 1'b1;
      end
    end
  endtask

  task automatic wait_rsp_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!rsp_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({name, "_rsp_valid"}, rsp_valid, 1);
  endtask

  // Requester model: note transfers before the edge, retire them after it.
  always @(negedge clk) xm <= req_valid & req_ready;

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < NREQ; i++)
      if (xm[i] && opq[i].size() != 0) opq[i].delete(0);
    for (int i = 0; i < NREQ; i++) begin
      if (opq[i].size() != 0) begin
        req_valid[i]     = 1'b1;
        req_a[i*8 +: 8]  = opq[i][0][15:8];
        req_b[i*8 +: 8]  = opq[i][0][7:0];
      end else begin
        req_valid[i]     = 1'b0;
        req_a[i*8 +: 8]  = '0;
        req_b[i*8 +: 8]  = '0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_rsp: got id %0d diff 0x%0h, expected no response", rsp_id, rsp_diff);
      end else begin
        check("rsp", {rsp_diff, rsp_borrow, rsp_ovf, rsp_id}, sb[0]);
        sb.delete(0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    step();
    step();

    // Reset state, then a single requester 0 transaction.
    put(0, 8'd3, 8'd1);
    exp_raw(8'h02, 1'b0, 1'b0, 2'd0);
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_fields", {rsp_diff, rsp_borrow, rsp_ovf, rsp_id}, 0);
    check("rst_op_count", op_count, 0);
    step();
    rst_n = 1'b1;
    @(negedge clk);
    check("grant0_ready", req_ready, 4'b0001);
    @(negedge clk);
    check("latency_valid", rsp_valid, 1);
    check("latency_count", op_count, 1);
    wait_idle("single");

    // Borrow / overflow boundaries, walking the pointer around to 0.
    put(1, 8'h04, 8'h05); exp_raw(8'hFF, 1'b1, 1'b0, 2'd1); wait_idle("borrow");
    put(2, 8'h80, 8'h01); exp_raw(8'h7F, 1'b0, 1'b1, 2'd2); wait_idle("ovf");
    put(3, 8'h81, 8'h81); exp_raw(8'h00, 1'b0, 1'b0, 2'd3); wait_idle("zero");
    check("count_after_bounds", op_count, 4);

    // All four valid together: ids 0..3 back to back.
    put(0, 8'd76, 8'd21);  put(1, 8'd49, 8'd24);
    put(2, 8'd113, 8'd57); put(3, 8'd97, 8'd33);
    exp_raw(8'd55, 1'b0, 1'b0, 2'd0); exp_raw(8'd25, 1'b0, 1'b0, 2'd1);
    exp_raw(8'd56, 1'b0, 1'b0, 2'd2); exp_raw(8'd64, 1'b0, 1'b0, 2'd3);
    start_cyc = cyc;
    wait_idle("all4");
    check("all4_cycles_ok", (cyc - start_cyc) <= 7, 1);
    check("count_after_all4", op_count, 8);

    // Backpressure: result held while others wait.
    step();
    rsp_ready = 1'b0;
    put(0, 8'hF8, 8'h02); exp_raw(8'hF6, 1'b0, 1'b0, 2'd0);
    wait_rsp_valid("bp");
    put(1, 8'h10, 8'h20); exp_raw(8'hF0, 1'b1, 1'b0, 2'd1);
    put(2, 8'h7F, 8'hFF); exp_raw(8'h80, 1'b1, 1'b1, 2'd2);
    put(3, 8'h00, 8'h80); exp_raw(8'h80, 1'b1, 1'b1, 2'd3);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_req_ready", req_ready, 0);
      check("bp_hold", {rsp_valid, rsp_diff, rsp_borrow, rsp_ovf, rsp_id}, {1'b1, 8'hF6, 1'b0, 1'b0, 2'd0});
    end
    step();
    rsp_ready = 1'b1;
    @(negedge clk);
    check("drain_grant", req_ready, 4'b0010);
    @(negedge clk);
    check("refill_valid_id", {rsp_valid, rsp_id}, {1'b1, 2'd1});
    wait_idle("bp");
    check("count_after_bp", op_count, 12);

    // Fairness: requesters 1 and 3 continuously valid for 20 grants.
    step();
    for (int k = 0; k < 10; k++) begin
      put(1, 8'(k*37 + 11), 8'(k*53 + 90));
      put(3, 8'(200 - k*19), 8'(k*23 + 7));
      sb.push_back(model(8'(k*37 + 11), 8'(k*53 + 90), 2'd1));
      sb.push_back(model(8'(200 - k*19), 8'(k*23 + 7), 2'd3));
    end
    start_cyc = cyc;
    wait_idle("fair");
    check("fair_cycles_ok", (cyc - start_cyc) <= 22, 1);
    check("count_after_fair", op_count, 32);

    // Reset while FULL with id 2: result discarded, pointer back to 0.
    step();
    rsp_ready = 1'b0;
    put(2, 8'h10, 8'h01); exp_raw(8'h0F, 1'b0, 1'b0, 2'd2);
    wait_rsp_valid("mid");
    check("mid_full_id", rsp_id, 2);
    put(1, 8'h30, 8'h10);
    put(3, 8'h05, 8'h06);
    step();
    step();
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check("mid_rst_req_ready", req_ready, 0);
    step();
    @(negedge clk);
    check("mid_rst_valid", rsp_valid, 0);
    check("mid_rst_count", op_count, 0);
    step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    exp_raw(8'h20, 1'b0, 1'b0, 2'd1);
    exp_raw(8'hFF, 1'b1, 1'b0, 2'd3);
    @(negedge clk);
    check("post_rst_first", req_ready, 4'b0010);
    wait_idle("post_rst");
    check("count_after_rst", op_count, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sub_share_arb.md
# sub_share_arb

Round-robin scheduler that shares one 8-bit subtractor datapath (`subtract_8bit`) between `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle, computes `a - b` through the shared subtractor, and returns the registered difference with borrow, signed-overflow and requester tag on a single valid/ready response channel. It sits between the arithmetic clients and the subtractor, replacing per-client subtractor copies.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, operand width; fixed at 8 for `subtract_8bit`
- `IDW`, `$clog2(NREQ)`, requester-tag width (derived, not overridden)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req_valid`  in  NREQ  per-requester operand valid
- `req_ready`  out  NREQ  per-requester grant; at most one bit set (one-hot or zero)
- `req_a`  in  NREQ*WIDTH  minuend; requester i uses bits [i*WIDTH +: WIDTH]
- `req_b`  in  NREQ*WIDTH  subtrahend; same packing
- `rsp_valid`  out  1  response holds a result
- `rsp_ready`  in  1  consumer accepts response
- `rsp_diff`  out  WIDTH  (a - b) mod 2^WIDTH
- `rsp_borrow`  out  1  1 when a < b (unsigned)
- `rsp_ovf`  out  1  signed (two's-complement) overflow of a - b
- `rsp_id`  out  IDW  index of the requester that produced the result
- `op_count`  out  16  number of completed grants, saturating at 0xFFFF

## Operation
- State: `IDLE` (output register empty) and `FULL` (`rsp_valid=1`, result held).
- Slot free: `rsp_valid==0`, or `rsp_valid && rsp_ready` in the same cycle (drain-and-refill).
- Grant when the slot is free and any `req_valid` is set. Winner g is the first set `req_valid[i]` scanning i = ptr, ptr+1, …, wrapping modulo NREQ.
- `req_ready[g]=1` combinationally in the grant cycle. All other `req_ready` bits are 0. A transfer occurs on `req_valid[g] && req_ready[g]`.
- On transfer:
  - `subtract_8bit` operands come from requester g.
  - The next edge loads `rsp_diff`, `rsp_borrow`, `rsp_ovf`, `rsp_id=g` and sets `rsp_valid=1`.
  - `ptr` becomes (g+1) mod NREQ.
  - `op_count` increments unless it is already 0xFFFF.
- No grant: `ptr` unchanged. If the slot was drained (`rsp_valid && rsp_ready`), `rsp_valid` goes to 0 → `IDLE`.
- `FULL` and `!rsp_ready`: every response output holds stable, and all `req_ready` = 0.
- Arithmetic:
  - `rsp_diff` = a + ~b + 1, truncated to WIDTH.
  - `rsp_borrow` = inverted carry-out.
  - `rsp_ovf` = (a[7] != b[7]) && (diff[7] != a[7]).
- `req_ready` may depend combinationally on `req_valid`. Requesters must not drive `req_valid` from `req_ready`. Once asserted, a requester's `req_valid` and operands stay stable until transfer.

## Timing
- Reset (`rst_n` low at an edge):
  - `rsp_valid=0`, `rsp_diff=0`, `rsp_borrow=0`, `rsp_ovf=0`, `rsp_id=0`, `ptr=0`, `op_count=0`.
  - `req_ready=0` throughout the reset cycle.
- Reset mid-operation: a held or pending result is discarded, with no response. The requester granted in that cycle is not counted.
- Latency: result visible exactly 1 cycle after the transfer edge.
- Throughput: 1 result/cycle with `rsp_ready` held high. With K requesters continuously valid, each is granted once every K cycles.
- Starvation bound: a continuously valid requester is granted within NREQ slot-free cycles.
- Simultaneous drain and grant: the new result replaces the old one on the same edge, and `rsp_valid` stays 1.
- `ptr` wrap: after granting NREQ-1, `ptr` = 0.

## Structure
- Shared package `sub_arb_pkg`: `WIDTH` constant; `arb_state_t` enum {`IDLE`, `FULL`}; result struct type `{diff, borrow, ovf, id}`.
- Sub-module: one instance of the existing `subtract_8bit(a, b, result)` as the shared datapath. Borrow and overflow are derived beside it from operand and result MSBs plus the carry path.
- Round-robin pick is a combinational function in the arbiter body. No separate module.

## Test plan
- Single requester 0: a=3, b=1 → next cycle `rsp_valid=1`, diff=0x02, borrow=0, ovf=0, id=0, `op_count=1`.
- All 4 valid, `rsp_ready=1`:
  - operands (76,21), (49,24), (113,57), (97,33) → ids 0,1,2,3 on consecutive cycles.
  - diffs 55, 25, 56, 64.
  - `ptr` wraps to 0.
- Backpressure: `rsp_ready=0` for 5 cycles with a result held (0xF8-0x02 → diff=0xF6, borrow=0):
  - all `req_ready` = 0;
  - outputs stable;
  - release → next grant on the same edge as drain.
- Borrow/overflow:
  - 0x04-0x05 → diff=0xFF, borrow=1, ovf=0.
  - 0x80-0x01 → diff=0x7F, ovf=1.
  - 0x81-0x81 → diff=0x00, borrow=0, ovf=0.
- Fairness: requesters 1 and 3 valid continuously for 20 cycles → grants strictly alternate 1,3,1,3; neither waits more than 2 cycles.
- Reset mid-operation: assert `rst_n=0` while `FULL` with id=2 → `rsp_valid=0`, `op_count=0`, `ptr=0`. First grant after release goes to the lowest valid index.
